freq_meter_calc_mc: RTL and testbench

//  Multi-channel equal-precision frequency meter core. Measures one of NUM_CH test clocks at a time.
//  The measurement gate is aligned to rising edges of the test clock; sys_clk is the standard clock.

---
 rtl/freq_meter_calc_mc.sv | 219 +++++++++++++++++++++
 tb/tb_freq_meter_calc_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_calc_mc.sv
// freq_meter_calc_mc
//   Multi-channel equal-precision frequency meter core. One test clock is
//   measured at a time. The gate opens and closes on rising edges of the
//   selected test clock, so the standard count always spans a whole number of
//   test periods. The result CLK_STAND_FREQ*cnt_test/cnt_stand is computed by
//   a serial restoring divider and returned over a valid/ready handshake.
//
// Ports
//   sys_clk     standard clock, all logic on its rising edge
//   sys_rst     synchronous active-high reset
//   clk_test    NUM_CH asynchronous test clocks
//   start       1-cycle pulse, starts a measurement on ch_sel (IDLE only)
//   ch_sel      channel for start; values >= NUM_CH are ignored
//   cont_mode   1 = restart on the next channel after each handshake
//   freq_ready  consumer accepts the result
//   freq_valid  result available, held until freq_ready
//   freq_data   frequency in Hz (floor), 0 on timeout, saturating
//   freq_ch     channel the result belongs to
//   no_signal   result is a timeout (qualified by freq_valid)
//   busy        high in every state except IDLE
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start
// SETTLE     | CNT_RISE_MAX cycles before looking for the opening edge
// WAIT_OPEN  | waiting for the first test-clock rise (gate open)
// MEAS       | counting until cnt_stand reaches GATE_LEN
// WAIT_CLOSE | waiting for the next test-clock rise (gate close)
// DIV        | serial restoring division, CNT_W+32 cycles
// DONE       | result presented, waiting for freq_ready

module freq_meter_calc_mc #(
  parameter int NUM_CH         = 4,
  parameter int CLK_STAND_FREQ = 50_000_000,
  parameter int CNT_GATE_S_MAX = 74_999_999,
  parameter int CNT_RISE_MAX   = 12_499_999,
  parameter int TIMEOUT_MAX    = 50_000_000,
  parameter int CNT_W          = 32,
  parameter int FREQ_W         = 32,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] clk_test,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              cont_mode,
  input  logic              freq_ready,
  output logic              freq_valid,
  output logic [FREQ_W-1:0] freq_data,
  output logic [CH_W-1:0]   freq_ch,
  output logic              no_signal,
  output logic              busy
);

  localparam int NUM_W    = CNT_W + 32;
  localparam int DIV_CW   = $clog2(NUM_W);
  localparam int GATE_LEN = CNT_GATE_S_MAX - 2 * CNT_RISE_MAX;
  localparam int PAD_N    = 2 ** CH_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_OPEN, S_MEAS, S_WAIT_CLOSE, S_DIV, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0] sync_1, sync_2, prev_q;
  logic [NUM_CH-1:0] rise;
  logic [PAD_N-1:0]  rise_pad;
  logic              rise_ch;

  logic [CH_W-1:0]   ch;
  logic [CNT_W-1:0]  settle_cnt, to_cnt, cnt_test, cnt_stand;
  logic [NUM_W-1:0]  num;
  logic [CNT_W-1:0]  rem;
  logic [DIV_CW-1:0] div_cnt;

  logic              ch_ok, handshake, timeout, entering;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W-1:0]  rem_sub, rem_nxt;
  logic              q_bit;
  logic [NUM_W-1:0]  num_nxt;
  logic [FREQ_W-1:0] freq_sat;

  // Synchronisers run on every channel all the time, so switching channels
  // needs no extra settle time.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
      prev_q <= '0;
    end else begin
      sync_1 <= clk_test;
      sync_2 <= sync_1;
      prev_q <= sync_2;
    end
  end

  assign rise = sync_2 & ~prev_q;

  // Padded so that the channel index is always in range for the select.
  always_comb begin
    rise_pad = '0;
    rise_pad[NUM_CH-1:0] = rise;
  end
  assign rise_ch = rise_pad[ch];

  assign ch_ok     = ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH));
  assign handshake = (state == S_DONE) && freq_ready;
  assign timeout   = (to_cnt == '0);
  assign entering  = (state_nxt != state);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start && ch_ok) state_nxt = S_SETTLE;
      S_SETTLE:     if (settle_cnt == '0) state_nxt = S_WAIT_OPEN;
      S_WAIT_OPEN: begin
        if (rise_ch)      state_nxt = S_MEAS;
        else if (timeout) state_nxt = S_DONE;
      end
      S_MEAS:       if (cnt_stand >= CNT_W'(GATE_LEN)) state_nxt = S_WAIT_CLOSE;
      S_WAIT_CLOSE: begin
        if (rise_ch)      state_nxt = S_DIV;
        else if (timeout) state_nxt = S_DONE;
      end
      S_DIV:        if (div_cnt == '0) state_nxt = S_DONE;
      S_DONE:       if (freq_ready) state_nxt = cont_mode ? S_SETTLE : S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // One restoring step; num shifts the numerator out at the top while the
  // quotient bits fill in at the bottom.
  always_comb begin
    rem_sh   = {rem, num[NUM_W-1]};
    q_bit    = (rem_sh >= {1'b0, cnt_stand});
    rem_sub  = rem_sh[CNT_W-1:0] - cnt_stand;
    rem_nxt  = q_bit ? rem_sub : rem_sh[CNT_W-1:0];
    num_nxt  = {num[NUM_W-2:0], q_bit};
    freq_sat = (|num_nxt[NUM_W-1:FREQ_W]) ? '1 : num_nxt[FREQ_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ch         <= '0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      cnt_test   <= '0;
      cnt_stand  <= '0;
      num        <= '0;
      rem        <= '0;
      div_cnt    <= '0;
      freq_data  <= '0;
      no_signal  <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_SETTLE) ch <= ch_sel;
      if (handshake && cont_mode)
        ch <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);

      if (entering && state_nxt == S_SETTLE) settle_cnt <= CNT_W'(CNT_RISE_MAX - 1);
      else if (settle_cnt != '0)             settle_cnt <= settle_cnt - CNT_W'(1);

      if (entering || rise_ch) to_cnt <= CNT_W'(TIMEOUT_MAX - 1);
      else if (!timeout)       to_cnt <= to_cnt - CNT_W'(1);

      case (state)
        S_WAIT_OPEN: begin
          if (rise_ch) begin
            // The opening-edge cycle is the first gated cycle and the closing
            // edge cycle is excluded, so cnt_stand spans exactly the periods.
            cnt_test  <= '0;
            cnt_stand <= CNT_W'(1);
          end else if (timeout) begin
            freq_data <= '0;
            no_signal <= 1'b1;
          end
        end
        S_MEAS: begin
          cnt_stand <= cnt_stand + CNT_W'(1);
          if (rise_ch) cnt_test <= cnt_test + CNT_W'(1);
        end
        S_WAIT_CLOSE: begin
          if (rise_ch) begin
            cnt_test <= cnt_test + CNT_W'(1);
            num      <= NUM_W'(CLK_STAND_FREQ) * NUM_W'(cnt_test + CNT_W'(1));
            rem      <= '0;
            div_cnt  <= DIV_CW'(NUM_W - 1);
          end else if (timeout) begin
            freq_data <= '0;
            no_signal <= 1'b1;
          end else begin
            cnt_stand <= cnt_stand + CNT_W'(1);
          end
        end
        S_DIV: begin
          num     <= num_nxt;
          rem     <= rem_nxt;
          div_cnt <= div_cnt - DIV_CW'(1);
          if (div_cnt == '0) begin
            freq_data <= freq_sat;
            no_signal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign freq_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign freq_ch    = ch;

endmodule

// File: tb/tb_freq_meter_calc_mc.sv
`timescale 1ns/1ps
module tb_freq_meter_calc_mc;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tc0 = 1'b0, tc1 = 1'b0, tc2 = 1'b0, tc3 = 1'b0;
  logic [3:0]  clk_test;
  logic        start = 1'b0, cont_mode = 1'b0, freq_ready = 1'b1;
  logic [1:0]  ch_sel = 2'd0;
  logic        freq_valid, no_signal, busy;
  logic [31:0] freq_data;
  logic [1:0]  freq_ch;

  logic        start2 = 1'b0;
  logic [1:0]  ch_sel2 = 2'd0;
  logic        freq_valid2, no_signal2, busy2;
  logic [31:0] freq_data2;
  logic [1:0]  freq_ch2;

  int vectors = 0;
  int miscompares = 0;

  always #10 sys_clk = ~sys_clk;               // 50 MHz
  initial begin #3; forever #100 tc0 = ~tc0; end  // 5 MHz
  initial begin #3; forever #500 tc1 = ~tc1; end  // 1 MHz
  initial begin #3; forever #30  tc3 = ~tc3; end  // 16.67 MHz
  assign clk_test = {tc3, tc2, tc1, tc0};         // ch2 tied low

  freq_meter_calc_mc #(
    .NUM_CH(4), .CLK_STAND_FREQ(50_000_000), .CNT_GATE_S_MAX(240),
    .CNT_RISE_MAX(40), .TIMEOUT_MAX(1000), .CNT_W(32), .FREQ_W(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_test(clk_test),
    .start(start), .ch_sel(ch_sel), .cont_mode(cont_mode),
    .freq_ready(freq_ready), .freq_valid(freq_valid), .freq_data(freq_data),
    .freq_ch(freq_ch), .no_signal(no_signal), .busy(busy)
  );

  // Three channels leave ch_sel=3 expressible as an out-of-range selection.
  freq_meter_calc_mc #(
    .NUM_CH(3), .CLK_STAND_FREQ(50_000_000), .CNT_GATE_S_MAX(240),
    .CNT_RISE_MAX(40), .TIMEOUT_MAX(1000), .CNT_W(32), .FREQ_W(32)
  ) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_test(clk_test[2:0]),
    .start(start2), .ch_sel(ch_sel2), .cont_mode(1'b0),
    .freq_ready(freq_ready), .freq_valid(freq_valid2), .freq_data(freq_data2),
    .freq_ch(freq_ch2), .no_signal(no_signal2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_start(input logic [1:0] c);
    start  = 1'b1;
    ch_sel = c;
    @(negedge sys_clk);
    start  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [1:0] c,
                               input logic [31:0] d, input logic ns, output int cyc);
    cyc = 0;
    while (!freq_valid && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
    end
    check({tag, "_valid"}, freq_valid, 1);
    check({tag, "_ch"}, freq_ch, c);
    check({tag, "_data"}, freq_data, d);
    check({tag, "_nosig"}, no_signal, ns);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  ok;

    // reset
    tick(3);
    check("rst_valid", freq_valid, 0);
    check("rst_data", freq_data, 0);
    check("rst_ch", freq_ch, 0);
    check("rst_nosig", no_signal, 0);
    check("rst_busy", busy, 0);
    check("rst_busy2", busy2, 0);
    sys_rst = 1'b0;
    tick(2);

    // single shot, ch0 5 MHz
    pulse_start(2'd0);
    check("t1_busy", busy, 1);
    expect_result("t1", 2'd0, 32'd5_000_000, 1'b0, cyc);
    tick(1);
    check("t1_valid_drop", freq_valid, 0);
    check("t1_idle", busy, 0);

    // ch1 1 MHz, ch3 16.67 MHz
    pulse_start(2'd1);
    expect_result("t2_ch1", 2'd1, 32'd1_000_000, 1'b0, cyc);
    tick(1);
    pulse_start(2'd3);
    expect_result("t2_ch3", 2'd3, 32'd16_666_666, 1'b0, cyc);
    tick(1);
    check("t2_idle", busy, 0);

    // back-pressure in DONE, with a start pulse that must be ignored
    freq_ready = 1'b0;
    pulse_start(2'd0);
    expect_result("t4", 2'd0, 32'd5_000_000, 1'b0, cyc);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin start = 1'b1; ch_sel = 2'd1; end
      if (i == 51) start = 1'b0;
      @(negedge sys_clk);
      if (!freq_valid || freq_data != 32'd5_000_000 || freq_ch != 2'd0 || !busy) ok = 1'b0;
    end
    check("t4_hold_stable", ok, 1);
    freq_ready = 1'b1;
    tick(1);
    check("t4_valid_drop", freq_valid, 0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (freq_valid || busy) ok = 1'b0;
    end
    check("t4_single_result", ok, 1);

    // continuous round robin
    cont_mode = 1'b1;
    pulse_start(2'd0);
    expect_result("t3_r0", 2'd0, 32'd5_000_000, 1'b0, cyc);
    tick(1);
    expect_result("t3_r1", 2'd1, 32'd1_000_000, 1'b0, cyc);
    tick(1);
    expect_result("t3_r2", 2'd2, 32'd0, 1'b1, cyc);
    check("t3_r2_timeout_time", (cyc >= 1030 && cyc <= 1050), 1);
    tick(1);
    expect_result("t3_r3", 2'd3, 32'd16_666_666, 1'b0, cyc);
    tick(1);
    cont_mode = 1'b0;
    expect_result("t3_r4", 2'd0, 32'd5_000_000, 1'b0, cyc);
    tick(1);
    check("t3_stop_idle", busy, 0);
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (freq_valid || busy) ok = 1'b0;
    end
    check("t3_no_extra", ok, 1);

    // start during MEAS is ignored
    pulse_start(2'd0);
    tick(100);
    check("t5_busy_meas", busy, 1);
    pulse_start(2'd1);
    expect_result("t5_ign", 2'd0, 32'd5_000_000, 1'b0, cyc);
    tick(1);

    // reset during MEAS aborts
    pulse_start(2'd3);
    tick(100);
    check("t5_ch_before_rst", freq_ch, 3);
    sys_rst = 1'b1;
    tick(1);
    check("t5_rst_valid", freq_valid, 0);
    check("t5_rst_data", freq_data, 0);
    check("t5_rst_ch", freq_ch, 0);
    check("t5_rst_nosig", no_signal, 0);
    check("t5_rst_busy", busy, 0);
    sys_rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (freq_valid || busy) ok = 1'b0;
    end
    check("t5_no_result", ok, 1);

    // out-of-range channel select on the 3-channel instance
    start2 = 1'b1; ch_sel2 = 2'd3;
    tick(1);
    start2 = 1'b0;
    check("t6_busy", busy2, 0);
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (freq_valid2 || busy2) ok = 1'b0;
    end
    check("t6_no_result", ok, 1);

    // same instance still measures on a legal channel (ch2 silent)
    start2 = 1'b1; ch_sel2 = 2'd2;
    tick(1);
    start2 = 1'b0;
    cyc = 0;
    while (!freq_valid2 && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("t6_legal_valid", freq_valid2, 1);
    check("t6_legal_ch", freq_ch2, 2);
    check("t6_legal_nosig", no_signal2, 1);
    check("t6_legal_data", freq_data2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
